// File: rtl/uart_stream_pkg.sv
// Shared definitions for the UART memory streamer.
//   state_t     : FSM state encoding used by uart_mem_streamer
//   nbytes()    : number of bytes in a memory word
//   data_w_ok() : legal word width (non-zero multiple of 8)
//   rd_lat_ok() : legal BRAM read latency (1 or 2)
package uart_stream_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_RWAIT  = 3'd2,
    ST_SEND   = 3'd3,
    ST_TXHOLD = 3'd4,
    ST_TXWAIT = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

  function automatic int nbytes(input int data_w);
    return data_w / 8;
  endfunction

  function automatic bit data_w_ok(input int data_w);
    return (data_w >= 8) && (data_w % 8 == 0);
  endfunction

  function automatic bit rd_lat_ok(input int rd_lat);
    return (rd_lat == 1) || (rd_lat == 2);
  endfunction

endpackage

// File: rtl/word_byte_serializer.sv
// Holds one memory word and presents it a byte at a time, LSB first.
//   clk, rst  : system clock, synchronous active-high reset
//   load      : capture word, restart at byte 0
//   word      : DATA_W-bit word to serialise
//   step      : advance to the next byte
//   cur_byte  : byte currently presented
//   last      : cur_byte is the final byte of the word
module word_byte_serializer
  import uart_stream_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] word,
  input  logic              step,
  output logic [7:0]        cur_byte,
  output logic              last
);

  localparam int NB    = nbytes(DATA_W);
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

  logic [DATA_W-1:0] shreg;
  logic [IDX_W-1:0]  idx;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
      idx   <= '0;
    end else if (load) begin
      shreg <= word;
      idx   <= '0;
    end else if (step) begin
      // Shifting keeps the outgoing byte at a fixed position, so no wide mux.
      shreg <= shreg >> 8;
      idx   <= idx + 1'b1;
    end
  end

  assign cur_byte = shreg[7:0];
  assign last     = (idx == IDX_W'(NB - 1));

endmodule

// File: rtl/uart_mem_streamer.sv
// Streams a BRAM address range, byte by byte (LSB first), into a UART
// transmitter using a start/busy handshake.
//   clk, rst              : system clock, synchronous active-high reset
//   start, abort          : transfer request (IDLE only) / cancel (non-IDLE)
//   base_addr, last_addr  : inclusive range, latched on accepted start
//   mem_ren, mem_addr     : BRAM read port; mem_rdata valid RD_LAT cycles later
//   tx_data, tx_start     : byte and load pulse to the UART
//   tx_busy               : UART busy, rises the cycle after tx_start
//   busy, done, aborted   : status (busy level, one-cycle pulses)
module uart_mem_streamer
  import uart_stream_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  if (!data_w_ok(DATA_W)) begin : g_bad_data_w
    $error("uart_mem_streamer: DATA_W must be a non-zero multiple of 8");
  end
  if (!rd_lat_ok(RD_LAT)) begin : g_bad_rd_lat
    $error("uart_mem_streamer: RD_LAT must be 1 or 2");
  end

  state_t            state, next_state;
  logic [ADDR_W-1:0] last_q;
  logic [1:0]        lat_cnt;
  logic              lat_done;
  logic              accept, addr_inc, ser_load, ser_step, ser_last;

  // The word is sampled on the last RWAIT cycle, RD_LAT cycles after mem_ren.
  assign lat_done = (lat_cnt == 2'(RD_LAT - 1));

  word_byte_serializer #(.DATA_W(DATA_W)) u_ser (
    .clk      (clk),
    .rst      (rst),
    .load     (ser_load),
    .word     (mem_rdata),
    .step     (ser_step),
    .cur_byte (tx_data),
    .last     (ser_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      mem_addr <= '0;
      last_q   <= '0;
      lat_cnt  <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        mem_addr <= base_addr;
        last_q   <= last_addr;
      end else if (addr_inc) begin
        mem_addr <= mem_addr + 1'b1;  // wraps naturally modulo 2^ADDR_W
      end
      lat_cnt <= (state == ST_RWAIT) ? lat_cnt + 1'b1 : 2'd0;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    next_state = state;
    mem_ren    = 1'b0;
    tx_start   = 1'b0;
    done       = 1'b0;
    aborted    = 1'b0;
    accept     = 1'b0;
    addr_inc   = 1'b0;
    ser_load   = 1'b0;
    ser_step   = 1'b0;

    // Abort outranks every action of the current state, including a
    // tx_start or done that would otherwise fire this cycle.
    if (state != ST_IDLE && abort) begin
      next_state = ST_IDLE;
      aborted    = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            accept     = 1'b1;
            next_state = ST_READ;
          end
        end
        ST_READ: begin
          mem_ren    = 1'b1;
          next_state = ST_RWAIT;
        end
        ST_RWAIT: begin
          if (lat_done) begin
            ser_load   = 1'b1;
            next_state = ST_SEND;
          end
        end
        ST_SEND: begin
          if (!tx_busy) begin
            tx_start   = 1'b1;
            next_state = ST_TXHOLD;
          end
        end
        // tx_busy is still low in the cycle right after tx_start; skip it.
        ST_TXHOLD: next_state = ST_TXWAIT;
        ST_TXWAIT: begin
          if (!tx_busy) begin
            if (!ser_last) begin
              ser_step   = 1'b1;
              next_state = ST_SEND;
            end else if (mem_addr == last_q) begin
              next_state = ST_DONE;
            end else begin
              addr_inc   = 1'b1;
              next_state = ST_READ;
            end
          end
        end
        ST_DONE: begin
          done       = 1'b1;
          next_state = ST_IDLE;
        end
        default: next_state = ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

endmodule
